instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  - Fetch stage directly upstream of instruction_memory: owns the PC, drives the memory address and
//    registers the returned word for decode.
//  - Handles sequential PC+4, branch/jump redirect, consumer stall, ECALL halt and illegal-PC fault.
//  - Sits between instruction_memory and the decoder/register-file stage of the lab CPU.
// PARAMETERS
//  - RESET_PC  default 32'h0000_0000  first fetch address after reset
//  - MEM_DEPTH default 1024           instruction words; legal PC range is [0, MEM_DEPTH*4)
// PORTS
//  - clk             in  1   clock
//  - reset           in  1   synchronous, active-high reset
//  - stall           in  1   decode not accepting; hold stage
//  - redirect_valid  in  1   taken branch/jump this cycle
//  - redirect_target in  32  new fetch PC
//  - imem_dout       in  32  instruction word from memory (asynchronous read of imem_addr)
//  - imem_addr       out 32  = fetch_pc (combinational from register)
//  - inst            out 32  registered instruction for decode
//  - inst_pc         out 32  PC of inst
//  - inst_valid      out 1   inst/inst_pc meaningful
//  - halted          out 1   stage stopped (ECALL or fault); sticky until reset
//  - fault           out 1   illegal PC (misaligned or out of range); sticky until reset
//  - fetch_count     out 32  only with FETCH_PERF_EN
// BEHAVIOUR
//  - Reset (clk edge with reset=1): fetch_pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_pc=0,
//    inst_valid=0, halted=0, fault=0, fetch_count=0, state=BOOT. Reset wins over every other input,
//    including mid-HALT/FAULT.
//  - BOOT: lasts exactly 1 cycle after reset deasserts (memory contents settle); no capture; -> RUN.
//  - RUN, latency 1: at each edge with stall=0 and no redirect: inst<=imem_dout, inst_pc<=fetch_pc,
//    inst_valid<=1, fetch_pc<=fetch_pc+4 (modulo 2^32).
//  - stall=1 (no redirect): fetch_pc, inst, inst_pc, inst_valid all hold.
//  - redirect_valid=1: priority over stall; fetch_pc<=redirect_target, inst_valid<=0 (wrong-path squash).
//  - ECALL: if a capture takes imem_dout==32'h0000_0073, the ECALL is delivered (inst_valid=1),
//    then state->HALT. In HALT: inst_valid<=0 next edge, halted=1, fetch_pc frozen; stall/redirect ignored.
//  - Illegal PC: if fetch_pc[1:0]!=0 or fetch_pc>=MEM_DEPTH*4 while in RUN, no capture occurs;
//    state->FAULT, fault=1, halted=1, inst_valid<=0. Applies to redirect targets and to sequential
//    wrap past the top of memory.
//  - ECALL and illegal-PC checks apply only to captures that actually occur (stall=0, no redirect).
//  - States: BOOT->RUN; RUN->HALT; RUN->FAULT; HALT and FAULT are terminal until reset.
// CONFIGURATION
//  - FETCH_PERF_EN defined: fetch_count port present; it increments on every edge where inst_valid
//    rises or a new capture sets it, i.e. one per delivered instruction (including the ECALL), and
//    saturates at 32'hFFFF_FFFF.
//  - FETCH_PERF_EN undefined: no counter logic and no fetch_count port.
// STRUCTURE
//  - Package fetch_pkg: state enum {BOOT,RUN,HALT,FAULT}, INST_ECALL=32'h0000_0073,
//    INST_NOP=32'h0000_0013, PC_STEP=4.
//  - One sub-module: fetch_perf_counter (saturating 32-bit counter), instantiated only under FETCH_PERF_EN.
//  - PC/FSM/capture registers stay in this module.
// TESTING
//  - Reset then run, memory words 0..3 = A0..A3 -> inst_valid first high 2 edges after reset
//    release; inst/inst_pc = A0/0, A1/4, A2/8 on consecutive cycles.
//  - stall=1 for 3 cycles while inst=A1 -> inst, inst_pc=4, inst_valid held; resumes with A2/8.
//  - redirect_valid=1, target=0x40, in the same cycle as stall=1 -> next cycle inst_valid=0,
//    imem_addr=0x40; following capture gives inst_pc=0x40.
//  - Word at 0xC = 0x00000073 -> delivered with inst_pc=0xC; next cycle inst_valid=0,
//    halted=1, imem_addr frozen at 0x10; redirects then ignored.
//  - redirect target 0x42 -> fault=1, halted=1, no capture.
//  - MEM_DEPTH=4, run from 0 -> fault at fetch_pc=0x10.
//  - Assert reset in HALT/FAULT -> all outputs at reset values.
//  - FETCH_PERF_EN with 5 delivered instructions -> fetch_count=5.
//  - Stalls and squashed redirects do not increment fetch_count.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [XLEN-1:0] INST_ECALL = 32'h0000_0073;
  localparam logic [XLEN-1:0] INST_NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  // A PC is unusable if it is not word aligned or lies past the last instruction word.
  function automatic logic pc_is_illegal(input logic [XLEN-1:0] pc, input int unsigned depth);
    return (pc[1:0] != 2'b00) || ({32'd0, pc} >= (64'(depth) * 64'd4));
  endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating 32-bit event counter for delivered instructions.
module fetch_perf_counter
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  output logic [XLEN-1:0] count
);

  logic [XLEN-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + XLEN'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory and registers the word for decode.
// Optional FETCH_PERF_EN adds the fetch_count port counting delivered instructions.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [XLEN-1:0] imem_dout,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  output logic            halted,
  output logic            fault
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] fetch_count
`endif
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_inst_valid;
  logic            r_halted;
  logic            r_fault;

  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic [XLEN-1:0] w_inst_nxt;
  logic [XLEN-1:0] w_inst_pc_nxt;
  logic            w_inst_valid_nxt;
  logic            w_halted_nxt;
  logic            w_fault_nxt;
  logic            w_pc_illegal;

  assign w_pc_illegal = pc_is_illegal(r_fetch_pc, MEM_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= BOOT;
      r_fetch_pc   <= RESET_PC;
      r_inst       <= INST_NOP;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_halted     <= w_halted_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

  // Redirect beats stall; legality and ECALL are judged only on a real capture.
  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;
    w_inst_valid_nxt = r_inst_valid;
    w_halted_nxt     = r_halted;
    w_fault_nxt      = r_fault;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          w_fetch_pc_nxt   = redirect_target;
          w_inst_valid_nxt = 1'b0;
        end else if (!stall) begin
          if (w_pc_illegal) begin
            w_state_nxt      = FAULT;
            w_fault_nxt      = 1'b1;
            w_halted_nxt     = 1'b1;
            w_inst_valid_nxt = 1'b0;
          end else begin
            w_inst_nxt       = imem_dout;
            w_inst_pc_nxt    = r_fetch_pc;
            w_inst_valid_nxt = 1'b1;
            w_fetch_pc_nxt   = r_fetch_pc + XLEN'(PC_STEP);
            if (imem_dout == INST_ECALL) begin
              w_state_nxt = HALT;
            end
          end
        end
      end
      HALT: begin
        w_inst_valid_nxt = 1'b0;
        w_halted_nxt     = 1'b1;
      end
      FAULT: begin
        w_inst_valid_nxt = 1'b0;
        w_halted_nxt     = 1'b1;
        w_fault_nxt      = 1'b1;
      end
      default: begin
        w_state_nxt = FAULT;
      end
    endcase
  end

  assign imem_addr  = r_fetch_pc;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_inst_valid;
  assign halted     = r_halted;
  assign fault      = r_fault;

`ifdef FETCH_PERF_EN
  logic w_capture;

  assign w_capture = (r_state == RUN) && !redirect_valid && !stall && !w_pc_illegal;

  fetch_perf_counter u_perf (
    .clk   (clk),
    .reset (reset),
    .inc   (w_capture),
    .count (fetch_count)
  );
`endif

endmodule
